ttt_game_ctrl: RTL
==================

# ttt_game_ctrl

Sequential tic-tac-toe game controller that sits directly upstream of the combinational win detector. It accepts one-hot moves through a valid/ready handshake and rejects illegal moves. It maintains both players' 9-bit occupancy registers (`ain`, `bin`) and drives them to the detector. It consumes the detector's 8-bit `win_line` to decide win, draw or next turn.

## Interface
- `FIRST_PLAYER`, default 0: player that moves after reset or `new_game`; 0 = A, 1 = B.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `new_game`  in  1  synchronous restart; same effect as reset, applied at the next edge.
- `move_valid`  in  1  a move is offered on `move_pos`.
- `move_pos`  in  9  one-hot cell index; bit 8 = top-left, bit 0 = bottom-right, matching detector bit order.
- `win_line`  in  8  one-hot line indication from the win detector, computed from this block's `ain`/`bin`.
- `move_ready`  out  1  high only in PLAY_A/PLAY_B.
- `move_err`  out  1  one-cycle pulse when an offered move is rejected.
- `ain`, `bin`  out  9 each  registered occupancy of player A / B.
- `turn`  out  1  0 = A to move, 1 = B to move; meaningful in PLAY states.
- `game_over`  out  1  high in DONE and DRAW.
- `winner`  out  2  00 none, 01 A, 10 B, 11 draw.
- `win_latched`  out  8  `win_line` captured at game end; 0 otherwise.

## Operation
- States: PLAY_A, PLAY_B, CHECK, DONE, DRAW. Reset state is PLAY_A, or PLAY_B if `FIRST_PLAYER` = 1.
- Reset values: `ain` = `bin` = 0, `move_err` = 0, `game_over` = 0, `winner` = 00, `win_latched` = 0, move count = 0, `turn` = `FIRST_PLAYER`.
- A move is accepted when `move_valid & move_ready` at an edge and the move is legal.
  - Legal means `move_pos` has exactly one bit set and `(ain|bin) & move_pos == 0`.
  - On acceptance, the mover's register ORs in `move_pos`, the 4-bit move count increments, and the state goes to CHECK.
  - The mover is remembered in a `last` flop.
- Illegal offer in a PLAY state: `move_err` = 1 for the next cycle. Board, count, state and turn are unchanged. The same player retries.
- `move_valid` outside PLAY states is ignored, with no error.
- CHECK samples `win_line`:
  - If `win_line` ≠ 0: go to DONE, `winner` = `last` (01 or 10), `win_latched` = `win_line`. Only the mover can complete a line.
  - Else if count = 9: go to DRAW, `winner` = 11.
  - Else: go to the other player's PLAY state and toggle `turn`.
- DONE and DRAW hold until `new_game` or `reset`.
- `new_game` has priority over any simultaneous move. The move is dropped and no `move_err` is raised.
- The count saturates logic-wise at 9; DRAW is reached before any 10th move is possible.

## Timing
- Handshake: the move is consumed at edge N. `ain`/`bin` are updated after N. The detector output settles combinationally. CHECK evaluates at edge N+1. `move_ready` for the next player is high after N+1.
  - Move-to-next-ready latency is 2 cycles. At most one move per 2 cycles.
- `move_err` asserts in the cycle after the offending edge and lasts exactly 1 cycle per rejected offer. A held illegal `move_valid` re-pulses every cycle.
- `game_over`/`winner` are valid the cycle after the CHECK edge.
- `reset` asserted mid-game, including during CHECK, clears all outputs asynchronously. The first legal move is accepted on the first edge after deassertion.

## Structure
- Shared package `ttt_pkg` holds:
  - the state enum;
  - winner codes NONE/A/B/DRAW;
  - `NUM_CELLS` = 9 and `NUM_LINES` = 8;
  - cell position constants (POS_TL … POS_BR).
- One sub-module, `ttt_move_check`: combinational onehot-and-free check. Inputs are `move_pos`, `ain`, `bin`; output is `legal`.
- The win detector is instantiated beside this block at the top level, not inside it.

## Test plan
- After reset, A plays 9'b100000000, B 9'b000010000, A 9'b010000000, B 9'b000000001, A 9'b001000000. Required: `winner` = 01, `win_latched` = 8'b00000001, `game_over` = 1, `ain` = 9'b111000000.
- A plays 9'b100000000, then B offers 9'b100000000. Required: `move_err` pulses 1 cycle, `bin` stays 0, `turn` stays 1. B then plays 9'b000000001 and it is accepted.
- Offer `move_pos` = 9'b000000011 and then 9'b0. Required: both are rejected with a `move_err` pulse and the state is unchanged.
- Full board with no line: A plays 8, 6, 3, 1, 2 and B plays 7, 4, 5, 0 (bit indices). Required after the 9th move: `winner` = 11, `win_latched` = 0.
- Assert `reset` asynchronously mid-CHECK after 3 moves. Required: `ain`/`bin` = 0 immediately, with no clock needed.
- Assert `new_game` together with a valid move. Required: board is cleared, the move is dropped, no `move_err`. Repeat with `FIRST_PLAYER` = 1: `turn` = 1 after restart.

Source files
------------

// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Package : ttt_pkg
// Purpose : Shared types and constants for the tic-tac-toe game controller.
//           Holds the controller state enum, winner codes, board dimensions
//           and one-hot cell position constants (bit 8 = top-left,
//           bit 0 = bottom-right, matching the win detector bit order).
// Revision: 1.0 - initial release
// ============================================================================
package ttt_pkg;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;

   typedef enum logic [2:0] {
      PLAY_A = 3'd0,
      PLAY_B = 3'd1,
      CHECK  = 3'd2,
      DONE   = 3'd3,
      DRAW   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_A    = 2'b01,
      WIN_B    = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   localparam logic [NUM_CELLS-1:0] POS_TL = 9'b100000000;
   localparam logic [NUM_CELLS-1:0] POS_TM = 9'b010000000;
   localparam logic [NUM_CELLS-1:0] POS_TR = 9'b001000000;
   localparam logic [NUM_CELLS-1:0] POS_ML = 9'b000100000;
   localparam logic [NUM_CELLS-1:0] POS_MM = 9'b000010000;
   localparam logic [NUM_CELLS-1:0] POS_MR = 9'b000001000;
   localparam logic [NUM_CELLS-1:0] POS_BL = 9'b000000100;
   localparam logic [NUM_CELLS-1:0] POS_BM = 9'b000000010;
   localparam logic [NUM_CELLS-1:0] POS_BR = 9'b000000001;

endpackage : ttt_pkg
`default_nettype wire

// File: rtl/ttt_move_check.sv
`default_nettype none
// ============================================================================
// Module  : ttt_move_check
// Purpose : Combinational legality check for an offered move: the position
//           must be exactly one-hot and must hit a free cell.
// Ports   : move_pos  in  9  offered one-hot cell
//           ain, bin  in  9  current occupancy of player A / B
//           legal     out 1  move is one-hot and the cell is empty
// Revision: 1.0 - initial release
// ============================================================================
module ttt_move_check
   import ttt_pkg::*;
(
   input  logic [NUM_CELLS-1:0] move_pos,
   input  logic [NUM_CELLS-1:0] ain,
   input  logic [NUM_CELLS-1:0] bin,
   output logic                 legal
);

   logic [NUM_CELLS-1:0] w_pos_m1;
   logic                 w_onehot;
   logic                 w_free;

   // x & (x-1) clears the lowest set bit; zero result with x != 0 means one-hot.
   assign w_pos_m1 = move_pos - NUM_CELLS'(1);
   assign w_onehot = (move_pos != '0) && ((move_pos & w_pos_m1) == '0);
   assign w_free   = ((move_pos & (ain | bin)) == '0);
   assign legal    = w_onehot && w_free;

endmodule : ttt_move_check
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ttt_game_ctrl
// Purpose : Sequential tic-tac-toe game controller. Accepts one-hot moves via
//           valid/ready, rejects illegal offers with a one-cycle error pulse,
//           keeps both players' occupancy registers and uses the external win
//           detector's line vector to decide win, draw or next turn.
// Ports   : clk          in  1  rising-edge clock
//           reset        in  1  asynchronous active-high reset
//           new_game     in  1  synchronous restart (beats any move)
//           move_valid   in  1  a move is offered on move_pos
//           move_pos     in  9  one-hot cell (bit 8 TL .. bit 0 BR)
//           win_line     in  8  line vector from the external win detector
//           move_ready   out 1  controller is waiting for a move
//           move_err     out 1  one-cycle pulse per rejected offer
//           ain, bin     out 9  registered occupancy of player A / B
//           turn         out 1  0 = A to move, 1 = B to move
//           game_over    out 1  game finished (win or draw)
//           winner       out 2  00 none, 01 A, 10 B, 11 draw
//           win_latched  out 8  win_line captured at the winning CHECK
// Revision: 1.0 - initial release
// ============================================================================
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter logic FIRST_PLAYER = 1'b0
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 new_game,
   input  logic                 move_valid,
   input  logic [NUM_CELLS-1:0] move_pos,
   input  logic [NUM_LINES-1:0] win_line,
   output logic                 move_ready,
   output logic                 move_err,
   output logic [NUM_CELLS-1:0] ain,
   output logic [NUM_CELLS-1:0] bin,
   output logic                 turn,
   output logic                 game_over,
   output logic [1:0]           winner,
   output logic [NUM_LINES-1:0] win_latched
);

   localparam state_t     START_STATE = FIRST_PLAYER ? PLAY_B : PLAY_A;
   localparam logic [3:0] MAX_MOVES   = 4'(NUM_CELLS);

   state_t     r_state;
   logic [3:0] r_count;
   logic       r_last;     // mover of the move currently being judged
   logic       w_legal;

   ttt_move_check u_move_check (
      .move_pos (move_pos),
      .ain      (ain),
      .bin      (bin),
      .legal    (w_legal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= START_STATE;
         r_count     <= 4'd0;
         r_last      <= FIRST_PLAYER;
         move_ready  <= 1'b1;
         move_err    <= 1'b0;
         ain         <= '0;
         bin         <= '0;
         turn        <= FIRST_PLAYER;
         game_over   <= 1'b0;
         winner      <= WIN_NONE;
         win_latched <= '0;
      end else if (new_game) begin
         // Restart wins over a simultaneous move: the offer is dropped silently.
         r_state     <= START_STATE;
         r_count     <= 4'd0;
         r_last      <= FIRST_PLAYER;
         move_ready  <= 1'b1;
         move_err    <= 1'b0;
         ain         <= '0;
         bin         <= '0;
         turn        <= FIRST_PLAYER;
         game_over   <= 1'b0;
         winner      <= WIN_NONE;
         win_latched <= '0;
      end else begin
         move_err <= 1'b0;
         case (r_state)
            PLAY_A, PLAY_B: begin
               if (move_valid) begin
                  if (w_legal) begin
                     if (r_state == PLAY_B) begin
                        bin <= bin | move_pos;
                     end else begin
                        ain <= ain | move_pos;
                     end
                     r_count    <= (r_count == MAX_MOVES) ? r_count : r_count + 4'd1;
                     r_last     <= (r_state == PLAY_B);
                     r_state    <= CHECK;
                     move_ready <= 1'b0;
                  end else begin
                     move_err <= 1'b1;
                  end
               end
            end
            CHECK: begin
               // The board already holds the new move, so win_line reflects it.
               if (win_line != '0) begin
                  r_state     <= DONE;
                  game_over   <= 1'b1;
                  winner      <= r_last ? WIN_B : WIN_A;
                  win_latched <= win_line;
               end else if (r_count == MAX_MOVES) begin
                  r_state   <= DRAW;
                  game_over <= 1'b1;
                  winner    <= WIN_DRAW;
               end else begin
                  r_state    <= r_last ? PLAY_A : PLAY_B;
                  turn       <= ~turn;
                  move_ready <= 1'b1;
               end
            end
            default: begin
               // DONE / DRAW hold until restart.
            end
         endcase
      end
   end

endmodule : ttt_game_ctrl
`default_nettype wire
